// File: rtl/pe_pkg.sv
// Shared constants and width helpers for the fixed-point MAC bank.
package pe_pkg;

  localparam logic RND_TRUNC    = 1'b0;
  localparam logic RND_HALF_UP  = 1'b1;

  function automatic int calc_w(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  function automatic int calc_p(input int w);
    return 2 * w;
  endfunction

  function automatic int calc_aw(input int p, input int guard_bits);
    return p + guard_bits;
  endfunction

  function automatic int calc_iw(input int num_acc);
    return $clog2(num_acc);
  endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Converts a wide accumulator to a W-bit result: optional half-up rounding,
// arithmetic shift by FRAC_BITS, then clamp to the signed W-bit range.
module pe_round_sat
  import pe_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC_BITS = 9,
  parameter int AW        = 36
) (
  input  logic [AW-1:0] acc,
  input  logic          rnd,
  output logic [W-1:0]  data,
  output logic          sat
);

  // One extra MSB keeps the rounding add from wrapping at the positive limit.
  localparam int EW = AW + 1;

  logic signed [EW-1:0] ext_s;
  logic signed [EW-1:0] rnd_s;
  logic signed [EW-1:0] sum_s;
  logic signed [EW-1:0] shr_s;
  logic signed [EW-1:0] max_s;
  logic signed [EW-1:0] min_s;

  // Round, shift and clamp.
  always_comb begin
    ext_s = {acc[AW-1], acc};
    rnd_s = '0;
    if (rnd == RND_HALF_UP) begin
      rnd_s[FRAC_BITS-1] = 1'b1;
    end else begin
      rnd_s[FRAC_BITS-1] = 1'b0;
    end
    sum_s = ext_s + rnd_s;
    shr_s = sum_s >>> FRAC_BITS;
    max_s = '0;
    max_s[W-2:0] = '1;
    min_s = '1;
    min_s[W-2:0] = '0;
    if (shr_s > max_s) begin
      data = max_s[W-1:0];
      sat  = 1'b1;
    end else if (shr_s < min_s) begin
      data = min_s[W-1:0];
      sat  = 1'b1;
    end else begin
      data = shr_s[W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/pe_mac_bank.sv
// Bank of NUM_ACC signed accumulators fed by a two-stage MAC pipeline,
// with a one-cycle-latency formatted read port.
module pe_mac_bank
  import pe_pkg::*;
#(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int NUM_ACC    = 8,
  parameter int GUARD_BITS = 4,
  localparam int W  = calc_w(INT_BITS, FRAC_BITS),
  localparam int P  = calc_p(W),
  localparam int AW = calc_aw(P, GUARD_BITS),
  localparam int IW = calc_iw(NUM_ACC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [IW-1:0] in_sel,
  input  logic          in_clear,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [IW-1:0] rd_sel,
  input  logic          rd_round,
  input  logic          rd_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_sat
);

  logic                 s1_valid_r;
  logic signed [P-1:0]  s1_prod_r;
  logic [IW-1:0]        s1_sel_r;
  logic                 s1_clear_r;
  logic signed [AW-1:0] acc_r [NUM_ACC];

  logic signed [P-1:0]  prod_s;
  logic signed [AW-1:0] prod_ext_s;
  logic signed [AW-1:0] acc_upd_s;
  logic [AW-1:0]        rd_val_s;
  logic                 mac_fire_s;
  logic                 rd_fire_s;
  logic [W-1:0]         fmt_data_s;
  logic                 fmt_sat_s;

  assign in_ready   = !rst;
  assign mac_fire_s = in_valid & in_ready;
  assign prod_s     = $signed({{W{in_a[W-1]}}, in_a}) * $signed({{W{in_b[W-1]}}, in_b});
  assign prod_ext_s = {{GUARD_BITS{s1_prod_r[P-1]}}, s1_prod_r};

  // A read of an index with a pending stage-1 op, or a stalled output, must wait.
  assign rd_ready  = !rst
                   & !(s1_valid_r & (s1_sel_r == rd_sel))
                   & !(out_valid & !out_ready);
  assign rd_fire_s = rd_valid & rd_ready;

  // Stage-2 accumulator update value.
  always_comb begin
    if (s1_clear_r) begin
      acc_upd_s = prod_ext_s;
    end else begin
      acc_upd_s = acc_r[s1_sel_r] + prod_ext_s;
    end
  end

  // Read value with same-cycle stage-2 write forwarded.
  always_comb begin
    if (s1_valid_r && (s1_sel_r == rd_sel)) begin
      rd_val_s = acc_upd_s;
    end else begin
      rd_val_s = acc_r[rd_sel];
    end
  end

  pe_round_sat #(
    .W         (W),
    .FRAC_BITS (FRAC_BITS),
    .AW        (AW)
  ) u_round_sat (
    .acc  (rd_val_s),
    .rnd  (rd_round),
    .data (fmt_data_s),
    .sat  (fmt_sat_s)
  );

  // Stage-1 product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_prod_r  <= '0;
      s1_sel_r   <= '0;
      s1_clear_r <= 1'b0;
    end else begin
      s1_valid_r <= mac_fire_s;
      s1_prod_r  <= prod_s;
      s1_sel_r   <= in_sel;
      s1_clear_r <= in_clear;
    end
  end

  // Accumulator bank; read-zero wins over a same-cycle stage-2 write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      if (s1_valid_r) begin
        acc_r[s1_sel_r] <= acc_upd_s;
      end
      if (rd_fire_s && rd_zero) begin
        acc_r[rd_sel] <= '0;
      end
    end
  end

  // Output register with hold-while-stalled behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (rd_fire_s) begin
      out_valid <= 1'b1;
      out_data  <= fmt_data_s;
      out_sat   <= fmt_sat_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_bank.sv
// Directed self-checking bench for pe_mac_bank at default parameters (1.0 = 0x0200).
module tb_pe_mac_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_sel;
  logic        in_clear;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_sel;
  logic        rd_round;
  logic        rd_zero;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mac_bank dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_clear  (in_clear),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_sel    (rd_sel),
    .rd_round  (rd_round),
    .rd_zero   (rd_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel, input logic clr);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_clear = clr;
    #1;
    chk("in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] sel, input logic rnd, input logic zero,
                    input logic [15:0] exp_data, input logic exp_sat);
    rd_valid = 1'b1;
    rd_sel   = sel;
    rd_round = rnd;
    rd_zero  = zero;
    #1;
    chk({tag, "_rd_ready"}, {31'd0, rd_ready}, 32'd1);
    step();
    rd_valid = 1'b0;
    rd_zero  = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_data});
    chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; in_sel = 3'd0;
    in_clear = 1'b0; rd_valid = 1'b0; rd_sel = 3'd0; rd_round = 1'b0; rd_zero = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    rst = 1'b0;
    #1;

    // Four MACs 1.5 x 1.0 into acc 3 -> 6.0
    mac(16'h0300, 16'h0200, 3'd3, 1'b1);
    mac(16'h0300, 16'h0200, 3'd3, 1'b0);
    mac(16'h0300, 16'h0200, 3'd3, 1'b0);
    mac(16'h0300, 16'h0200, 3'd3, 1'b0);
    repeat (2) step();
    rd("acc3", 3'd3, 1'b0, 1'b0, 16'h0C00, 1'b0);

    // Saturation both directions
    mac(16'h7FFF, 16'h7FFF, 3'd0, 1'b1);
    repeat (2) step();
    rd("satpos", 3'd0, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    mac(16'h8000, 16'h7FFF, 3'd0, 1'b1);
    repeat (2) step();
    rd("satneg", 3'd0, 1'b0, 1'b0, 16'h8000, 1'b1);

    // Rounding modes
    mac(16'h0001, 16'h0100, 3'd1, 1'b1);
    repeat (2) step();
    rd("half_trunc", 3'd1, 1'b0, 1'b0, 16'h0000, 1'b0);
    rd("half_round", 3'd1, 1'b1, 1'b0, 16'h0001, 1'b0);
    mac(16'hFE00, 16'h0001, 3'd1, 1'b1);
    repeat (2) step();
    rd("neg_trunc", 3'd1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    rd("neg_round", 3'd1, 1'b1, 1'b0, 16'hFFFF, 1'b0);

    // Read-after-MAC hazard on acc 5; unrelated index proceeds
    mac(16'h0200, 16'h0200, 3'd5, 1'b1);
    repeat (2) step();
    mac(16'h0200, 16'h0200, 3'd5, 1'b0);
    rd_valid = 1'b1; rd_sel = 3'd5; rd_round = 1'b0; rd_zero = 1'b0;
    #1;
    chk("haz_rd_ready_low", {31'd0, rd_ready}, 32'd0);
    step();
    rd_valid = 1'b0;
    chk("haz_no_accept", {31'd0, out_valid}, 32'd0);
    rd("haz_acc5", 3'd5, 1'b0, 1'b0, 16'h0400, 1'b0);
    step();
    mac(16'h0200, 16'h0200, 3'd5, 1'b0);
    rd("other_acc2", 3'd2, 1'b0, 1'b0, 16'h0000, 1'b0);
    step();
    rd("acc5_after", 3'd5, 1'b0, 1'b0, 16'h0600, 1'b0);

    // Output backpressure, then read-with-zero
    rd("bp_read", 3'd3, 1'b0, 1'b0, 16'h0C00, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rd_ready", {31'd0, rd_ready}, 32'd0);
      step();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, out_data}, 32'h0C00);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, rd_ready}, 32'd1);
    step();
    chk("bp_drop", {31'd0, out_valid}, 32'd0);
    rd("zero_read", 3'd3, 1'b0, 1'b1, 16'h0C00, 1'b0);
    rd("after_zero", 3'd3, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset mid-flight with stage 1 and output both valid
    in_valid = 1'b1; in_a = 16'h0200; in_b = 16'h0200; in_sel = 3'd4; in_clear = 1'b1;
    rd_valid = 1'b1; rd_sel = 3'd5; rd_round = 1'b0;
    step();
    in_valid = 1'b0; rd_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("in_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("in_rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_data", {16'd0, out_data}, 32'd0);
    chk("post_rst_sat", {31'd0, out_sat}, 32'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      rd("rst_acc", 3'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_mac_bank.md
PE_MAC_BANK -- requirements
Module: pe_mac_bank

Interface
REQ-001 The block SHALL have parameter INT_BITS, default 7, integer bits of the signed fixed-point operand.
REQ-002 The block SHALL have parameter FRAC_BITS, default 9, fraction bits; W = INT_BITS+FRAC_BITS, P = 2*W.
REQ-003 The block SHALL have parameter NUM_ACC, default 8, accumulator count, power of two >= 2; IW = clog2(NUM_ACC).
REQ-004 The block SHALL have parameter GUARD_BITS, default 4, extra accumulator MSBs; AW = P+GUARD_BITS.
REQ-005 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MAC request valid.
- in_ready  out  1  MAC request accepted when high with in_valid.
- in_a, in_b  in  W each  signed Q(INT_BITS).(FRAC_BITS) operands.
- in_sel  in  IW  target accumulator.
- in_clear  in  1  1 = overwrite accumulator with product; 0 = add product.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted when high with rd_valid.
- rd_sel  in  IW  accumulator to read.
- rd_round  in  1  0 = truncate toward -inf; 1 = round half up.
- rd_zero  in  1  zero the accumulator at read acceptance.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when high with out_valid.
- out_data  out  W  rounded, saturated result.
- out_sat  out  1  result was clamped.

Function
REQ-006 in_ready SHALL be 1 in every non-reset cycle; MAC transfer = in_valid & in_ready.
REQ-007 Stage 1: the full signed P-bit product SHALL be registered with valid, sel and clear one cycle after transfer.
REQ-008 Stage 2: in the following cycle, acc[sel] SHALL be updated to sign-extended product (clear=1) or acc[sel]+product modulo 2^AW (clear=0); back-to-back MACs to the same index SHALL all be accumulated.
REQ-009 rd_ready SHALL be 0 when stage 1 holds a valid op with sel == rd_sel, or when out_valid & !out_ready; otherwise 1.
REQ-010 An accepted read SHALL sample acc[rd_sel] including any stage-2 update of the same cycle (forwarded) and present the result with out_valid on the next cycle (latency 1).
REQ-011 Formatting: optionally add 2^(FRAC_BITS-1) (rd_round=1), arithmetic shift right by FRAC_BITS, clamp to [-2^(W-1), 2^(W-1)-1]; out_sat = 1 iff clamped.
REQ-012 rd_zero=1 SHALL set acc[rd_sel] to 0 at the acceptance edge, overriding a same-cycle stage-2 write to that index, whose contribution is already in the read value.
REQ-013 out_data/out_sat SHALL be held stable while out_valid & !out_ready; out_valid SHALL drop after a transfer unless a new read is accepted in the same cycle.
REQ-014 MAC and read traffic to different indices SHALL proceed concurrently without stalls.

Reset
REQ-015 While rst is 1: all accumulators 0, stage-1 valid 0, out_valid 0, out_data 0, out_sat 0, in_ready 0, rd_ready 0.
REQ-016 Reset asserted mid-operation SHALL discard in-flight MACs and pending output; the first transfer is possible in the cycle after rst falls.

Structure
REQ-017 Package pe_pkg SHALL hold the rd_round encoding constants and width helper functions (W, P, AW, IW).
REQ-018 Rounding and saturation SHALL be a sub-module pe_round_sat (combinational, AW in, W plus sat flag out).

Verification (defaults, 1.0 = 0x0200)
REQ-019 Four MACs 0x0300 x 0x0200 to acc 3 (first with in_clear), read after drain -> out_data 0x0C00, out_sat 0.
REQ-020 0x7FFF x 0x7FFF into acc 0, read -> out_data 0x7FFF, out_sat 1; 0x8000 x 0x7FFF -> 0x8000, out_sat 1.
REQ-021 0x0001 x 0x0100, read rd_round=0 -> 0x0000; same with rd_round=1 -> 0x0001; 0xFE00 x 0x0001 -> 0xFFFF for both modes.
REQ-022 MAC to acc 5 at cycle t, read acc 5 at t+1 -> rd_ready 0 at t+1, accepted at t+2, result includes the MAC; read acc 2 at t+1 -> accepted immediately.
REQ-023 out_ready held 0 for 3 cycles -> out_data stable, rd_ready 0; read with rd_zero, then read again -> 0x0000.
REQ-024 rst pulsed with stage 1 and output valid -> all outputs 0 next cycle, every accumulator reads 0x0000.
